// File: rtl/divider_quotient_reconstructor.sv
// Rebuilds a 16/8 divider dividend as q*d + r with an 8-cycle LSB-first shift-add loop.
// It reports the signed 17-bit error of the rebuilt value against the reference dividend.
module divider_quotient_reconstructor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  q,
  input  logic [7:0]  r,
  input  logic [7:0]  d,
  input  logic [15:0] n_ref,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] n_rec,
  output logic [16:0] err,
  output logic        mismatch
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [15:0] r_nref;
  logic [2:0]  r_cnt;
  logic [15:0] r_nrec;
  logic [16:0] r_err;
  logic        r_mismatch;

  logic [15:0] w_accNext;
  logic [16:0] w_errNext;

  // The peak of q*d + r is 65280, so the 16-bit accumulator never wraps.
  always_comb begin
    w_accNext = r_acc;
    if (r_mplier[0]) begin
      w_accNext = r_acc + r_mcand;
    end
    w_errNext = {1'b0, w_accNext} - {1'b0, r_nref};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_nref     <= '0;
      r_cnt      <= '0;
      r_nrec     <= '0;
      r_err      <= '0;
      r_mismatch <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc    <= {8'd0, r};
            r_mcand  <= {8'd0, d};
            r_mplier <= q;
            r_nref   <= n_ref;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_acc    <= w_accNext;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[7:1]};
          r_cnt    <= r_cnt + 3'd1;
          // Last bit: the result registers load from the final sum on this same edge.
          if (r_cnt == 3'd7) begin
            r_nrec     <= w_accNext;
            r_err      <= w_errNext;
            r_mismatch <= (w_errNext != 17'd0);
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign n_rec     = r_nrec;
  assign err       = r_err;
  assign mismatch  = r_mismatch;

endmodule

// File: tb/tb_divider_quotient_reconstructor.sv
// Directed and randomized checks of divider_quotient_reconstructor against q*d + r arithmetic.
module tb_divider_quotient_reconstructor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic [7:0]  r;
  logic [7:0]  d;
  logic [15:0] n_ref;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] n_rec;
  logic [16:0] err;
  logic        mismatch;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  divider_quotient_reconstructor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .r         (r),
    .d         (d),
    .n_ref     (n_ref),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n_rec     (n_rec),
    .err       (err),
    .mismatch  (mismatch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives operands at a falling edge and lets the next rising edge accept them.
  task automatic applyStimulus(input logic [7:0] qi, input logic [7:0] di,
                               input logic [7:0] ri, input logic [15:0] ni);
    @(negedge clk);
    q = qi; d = di; r = ri; n_ref = ni;
    in_valid = 1'b1;
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q = ~qi; d = ~di; r = ~ri; n_ref = ~ni;
  endtask

  // Counts rising edges after accept until out_valid is seen, bounded.
  task automatic waitResult(input string tag);
    int cycles;
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end while (!out_valid && cycles < 30);
    checkOutput({tag, "_latency"}, cycles, 32'd8);
  endtask

  task automatic checkModel(input string tag, input logic [7:0] qi, input logic [7:0] di,
                            input logic [7:0] ri, input logic [15:0] ni);
    int expRec;
    int expErr;
    logic [16:0] expErrBits;
    expRec     = int'(qi) * int'(di) + int'(ri);
    expErr     = expRec - int'(ni);
    expErrBits = 17'(expErr);
    checkOutput({tag, "_n_rec"}, {16'd0, n_rec}, 32'(expRec));
    checkOutput({tag, "_err"}, {15'd0, err}, {15'd0, expErrBits});
    checkOutput({tag, "_mismatch"}, {31'd0, mismatch}, {31'd0, (expErr != 0)});
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic doSample(input string tag, input logic [7:0] qi, input logic [7:0] di,
                          input logic [7:0] ri, input logic [15:0] ni);
    applyStimulus(qi, di, ri, ni);
    waitResult(tag);
    checkModel(tag, qi, di, ri, ni);
    handshake();
  endtask

  initial begin
    logic [15:0] heldRec;
    logic [16:0] heldErr;
    logic [7:0]  rq, rd, rr;
    logic [15:0] rn;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q = '0; d = '0; r = '0; n_ref = '0;
    #12;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_n_rec", {16'd0, n_rec}, 32'd0);
    checkOutput("reset_err", {15'd0, err}, 32'd0);
    checkOutput("reset_mismatch", {31'd0, mismatch}, 32'd0);
    rst_n = 1'b1;

    doSample("exact", 8'd142, 8'd7, 8'd6, 16'd1000);
    checkOutput("exact_err_const", {15'd0, err}, 32'h00000);
    doSample("max", 8'd255, 8'd255, 8'd255, 16'd0);
    checkOutput("max_err_const", {15'd0, err}, 32'h0FF00);
    doSample("negext", 8'd0, 8'd0, 8'd0, 16'd65535);
    checkOutput("negext_err_const", {15'd0, err}, 32'h10001);
    doSample("approx", 8'd141, 8'd7, 8'd6, 16'd1000);
    checkOutput("approx_err_const", {15'd0, err}, 32'h1FFF9);
    doSample("d_zero", 8'd200, 8'd0, 8'd77, 16'd77);
    doSample("q_zero", 8'd0, 8'd99, 8'd13, 16'd14);

    // Backpressure: result held while new operands wait at the input.
    applyStimulus(8'd100, 8'd200, 8'd50, 16'd20050);
    waitResult("bp");
    checkModel("bp", 8'd100, 8'd200, 8'd50, 16'd20050);
    heldRec = n_rec;
    heldErr = err;
    q = 8'd12; d = 8'd34; r = 8'd5; n_ref = 16'd400;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_n_rec_stable", {16'd0, n_rec}, {16'd0, heldRec});
      checkOutput("bp_err_stable", {15'd0, err}, {15'd0, heldErr});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_after_hs_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_after_hs_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitResult("bp_next");
    checkModel("bp_next", 8'd12, 8'd34, 8'd5, 16'd400);
    handshake();

    // Reset during the 4th BUSY cycle drops the sample and clears outputs.
    applyStimulus(8'd77, 8'd88, 8'd9, 16'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_n_rec", {16'd0, n_rec}, 32'd0);
    checkOutput("rst_mid_err", {15'd0, err}, 32'd0);
    checkOutput("rst_mid_mismatch", {31'd0, mismatch}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rst_release_no_output", {31'd0, out_valid}, 32'd0);
    doSample("post_rst", 8'd3, 8'd5, 8'd1, 16'd16);

    for (int i = 0; i < 20; i++) begin
      rq = 8'($urandom);
      rd = 8'($urandom);
      rr = 8'($urandom);
      rn = ($urandom_range(0, 1) == 1) ? 16'(int'(rq) * int'(rd) + int'(rr)) : 16'($urandom);
      doSample($sformatf("rand%0d", i), rq, rd, rr, rn);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/divider_quotient_reconstructor.md
# divider_quotient_reconstructor

Sequential checker that reverses the 16-by-8 array divider. It takes a divider result (quotient `q`, remainder `r`), the divisor `d` and the original dividend `n_ref`, and rebuilds the dividend as q·d + r using an 8-cycle shift-add datapath. It reports the signed reconstruction error against `n_ref`. It sits behind the exact and approximate divider arrays in the characterization harness and streams per-sample error to the area/MSE accumulators.

## Interface
- No parameters. Widths are fixed to match the 16/8 divider arrays.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: operand set is valid.
- `in_ready` output 1: block can accept operands.
- `q` input 8: quotient from the divider.
- `r` input 8: remainder from the divider.
- `d` input 8: divisor.
- `n_ref` input 16: original dividend.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: downstream accepts the result.
- `n_rec` output 16: reconstructed dividend, q·d + r.
- `err` output 17: signed two's complement, `n_rec − n_ref`.
- `mismatch` output 1: high when `err` ≠ 0.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`, capture operands as follows: accumulator ← zero-extended `r` (16 b); multiplicand register ← zero-extended `d` (16 b); multiplier register ← `q`; `n_ref` captured.
  - Bit counter ← 0. Go to BUSY.
- **BUSY:** one quotient bit per cycle, LSB first.
  - If multiplier[0] = 1, accumulator += multiplicand (16-bit add).
  - Multiplicand <<= 1. Multiplier >>= 1. Counter += 1.
  - On the cycle the counter = 7, the update is applied and the result registers are loaded in the same edge: `n_rec` ← final accumulator, `err` ← {0,final} − {0,`n_ref`}, `mismatch` ← (`err` ≠ 0). Go to DONE.
- **DONE:**
  - `out_valid` = 1. All outputs are held stable.
  - On `out_ready` go to IDLE.
- **Arithmetic:**
  - Maximum q·d + r = 255·255 + 255 = 65280, which fits in 16 bits. The accumulator never overflows, so no saturation is needed.
  - `err` range is −65535 to +65280. It is computed in 17 bits and sign-correct.
- **d = 0:** result is `r`, the multiplier loop has no effect.
- **q = 0:** result is `r`.
- **Inputs outside IDLE:** `in_valid` is ignored in BUSY and DONE. Operands are registered on accept, so input changes after acceptance have no effect.
- **Reset:**
  - Assertion at any time, including mid-BUSY or in DONE, forces state IDLE and clears all registers. The in-flight sample is dropped with no output.
  - Reset values: `in_ready` = 1 (IDLE), `out_valid` = 0, `n_rec` = 0, `err` = 0, `mismatch` = 0.

## Timing
- Accept on clock edge E0. BUSY occupies edges E1–E8. `out_valid` rises after E8.
- Fixed latency is 8 cycles from accept to `out_valid`, independent of operand values.
- `in_ready` is combinational from state: high only in IDLE.
- No same-cycle accept in DONE. After the output handshake at edge Ek, IDLE starts at Ek+1 and the next accept is no earlier than Ek+1.
- Best-case throughput: one sample per 10 cycles, with `out_ready` held high.
- `out_valid` stays asserted until the handshake. `n_rec`, `err` and `mismatch` are registered and unchanged while `out_valid` is high.
- No combinational path from inputs to `out_valid`, `n_rec`, `err` or `mismatch`.

## Test plan
- **Exact result:** `n_ref`=1000, `d`=7, `q`=142, `r`=6.
  - `n_rec`=1000, `err`=0, `mismatch`=0.
  - `out_valid` rises exactly 8 cycles after accept.
- **Maximum operands:** `q`=255, `d`=255, `r`=255, `n_ref`=0.
  - `n_rec`=65280, `err`=+65280 (17'h0FF00), `mismatch`=1.
- **Negative extreme:** `q`=0, `d`=0, `r`=0, `n_ref`=65535.
  - `n_rec`=0, `err`=−65535 (17'h10001), `mismatch`=1.
- **Approximate-divider error:** `n_ref`=1000, `d`=7, `q`=141, `r`=6.
  - `n_rec`=993, `err`=−7 (17'h1FFF9), `mismatch`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE while `in_valid`=1 with new operands.
  - Outputs stay stable and `in_ready`=0.
  - Raise `out_ready`: handshake completes, IDLE starts the next cycle, and the new operands are accepted then.
- **Reset mid-operation:** pulse `rst_n` low at the 4th BUSY cycle.
  - `out_valid`=0 immediately; `n_rec`, `err` and `mismatch` all read 0.
  - `in_ready`=1 after release.
  - The subsequent sample `q`=3, `d`=5, `r`=1, `n_ref`=16 yields `n_rec`=16, `err`=0.
